mem_stream_writer: RTL

MEM_STREAM_WRITER -- requirements
Module: mem_stream_writer

---
 rtl/mem_stream_writer_pkg.sv | 20 ++
 rtl/mem_stream_writer_packer.sv | 51 +++++
 rtl/mem_stream_writer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_stream_writer_pkg.sv
// Shared definitions for the stream-to-memory writer and the memory it targets.
// Holds the FSM state encoding and the default memory geometry.
package mem_stream_writer_pkg;

    localparam int DEPTH_DEFAULT  = 5120;
    localparam int ADDR_W_DEFAULT = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One-hot byte-lane mask for a little-endian lane index.
    function automatic logic [3:0] lane_bit(input logic [1:0] lane);
        return 4'(4'b0001 << lane);
    endfunction

endpackage

// File: rtl/mem_stream_writer_packer.sv
// Accumulates stream bytes into a 32-bit little-endian word with per-lane
// byte enables; cleared between words by the owning FSM.
module stream_byte_packer
    import mem_stream_writer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  data_i,
    output logic        last_lane_o,
    output logic [31:0] word_o,
    output logic [3:0]  be_o
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  be_q,   be_d;

    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        be_d   = be_q;
        if (clear_i) begin
            lane_d = '0;
            word_d = '0;
            be_d   = '0;
        end else if (accept_i) begin
            word_d[{lane_q, 3'b000} +: 8] = data_i;
            be_d                          = be_q | lane_bit(lane_q);
            lane_d                        = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
            be_q   <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            be_q   <= be_d;
        end
    end

    assign last_lane_o = (lane_q == 2'd3);
    assign word_o      = word_q;
    assign be_o        = be_q;

endmodule

// File: rtl/mem_stream_writer.sv
// Packs a byte stream into 32-bit words and writes them to consecutive word
// addresses with Avalon-style waitrequest handshaking; wraps at DEPTH.
module mem_stream_writer
    import mem_stream_writer_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic              in_ready_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic              wrapped_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;

    logic              accept;
    logic              pk_clear;
    logic              pk_last_lane;
    logic [31:0]       pk_word;
    logic [3:0]        pk_be;

    assign accept   = in_valid & in_ready_q;
    // Lanes restart on every new command and after every completed write.
    assign pk_clear = ((state_q == IDLE) & start) | ((state_q == WRITE) & ~waitrequest);

    stream_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (pk_clear),
        .accept_i    (accept),
        .data_i      (in_data),
        .last_lane_o (pk_last_lane),
        .word_o      (pk_word),
        .be_o        (pk_be)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrapped_q  <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_q     <= base_addr;
                            rem_q      <= length;
                            wrapped_q  <= 1'b0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= FILL;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (pk_last_lane || (rem_q == LEN_W'(1))) begin
                            in_ready_q <= 1'b0;
                            wr_q       <= 1'b1;
                            state_q    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (!waitrequest) begin
                        wr_q <= 1'b0;
                        if (rem_q == '0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            if (addr_q == LAST_ADDR) begin
                                addr_q    <= '0;
                                wrapped_q <= 1'b1;
                            end else begin
                                addr_q <= addr_q + ADDR_W'(1);
                            end
                            in_ready_q <= 1'b1;
                            state_q    <= FILL;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign chipselect = wr_q;
    assign write      = wr_q;
    assign address    = addr_q;
    // Outside a write the data and lane bus rest at zero.
    assign writedata  = wr_q ? pk_word : 32'h0;
    assign byteenable = wr_q ? pk_be : 4'h0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign wrapped    = wrapped_q;

endmodule
